// File: rtl/shift_add_multiplier_pkg.sv
// shift_add_multiplier_pkg: shared state encoding and constants for the multiplier
package shift_add_multiplier_pkg;
  localparam int DATA_W = 8;
  localparam int ITER_COUNT = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: start/busy/done handshake plus operand and product bus
interface shift_add_multiplier_if;
  import shift_add_multiplier_pkg::*;
  logic start;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic busy;
  logic done;
  logic [2*DATA_W-1:0] Product;
  modport master(output start, A, B, input busy, done, Product);
  modport slave(input start, A, B, output busy, done, Product);
endinterface

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: 8-bit ripple-carry adder built from a chain of full adders
module ripple_carry_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;
  assign c[0] = cin;
  assign cout = c[8];
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 8x8 unsigned shift-and-add multiplier with start/busy/done handshake
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  shift_add_multiplier_if.slave bus
);
  if (WIDTH != 8) begin : g_bad_width
    $error("shift_add_multiplier: WIDTH must be 8 to match the fixed 8-bit adder");
  end
  state_t state_q, state_d;
  logic [7:0] m, acc, q;
  logic [3:0] count;
  logic [15:0] product;
  logic [7:0] sum;
  logic cout, is_idle, is_run, last;
  // the unused encoding 2'd3 behaves exactly like IDLE
  assign is_idle = !(state_q inside {RUN, DONE});
  assign is_run = state_q == RUN;
  assign last = count == 4'(ITER_COUNT - 1);
  assign bus.busy = is_run;
  assign bus.done = state_q == DONE;
  assign bus.Product = product;
  ripple_carry_adder u_adder (
    .a(acc),
    .b(q[0] ? m : 8'h00),
    .cin(1'b0),
    .sum(sum),
    .cout(cout)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next-state: accept in IDLE, iterate in RUN, single-cycle DONE
  always_comb begin
    state_d = IDLE;
    state_d = is_idle ? (bus.start ? RUN : IDLE) : is_run ? (last ? DONE : RUN) : IDLE;
  end
  // datapath: latch operands on accept, shift {Cout,Sum,Q} right once per RUN cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m <= '0;
      acc <= '0;
      q <= '0;
      count <= '0;
      product <= '0;
    end else if (is_idle && bus.start) begin
      m <= bus.A;
      q <= bus.B;
      acc <= '0;
      count <= '0;
    end else if (is_run) begin
      {acc, q} <= {cout, sum, q[7:1]};
      count <= count + 4'd1;
      if (last) product <= {cout, sum, q[7:1]};
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: randomized and directed checks against an arithmetic reference
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] prev_prod = 16'h0;
  shift_add_multiplier_if bus ();
  shift_add_multiplier #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one multiply: checks busy span, done latency, product hold and final product
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit repulse);
    int busy_cycles = 0;
    int done_at = 0;
    logic [15:0] expv = 16'(a) * 16'(b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.A = 8'($urandom);
        bus.B = 8'($urandom);
      end
      if (repulse && i == 3) begin
        bus.start = 1'b1;
        bus.A = 8'hFF;
        bus.B = 8'hFF;
      end
      if (repulse && i == 4) bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      if (i == 5) chk("product_hold", bus.Product, prev_prod);
      if (bus.done) begin
        done_at = i;
        break;
      end
    end
    chk("done_latency", done_at, 9);
    chk("busy_cycles", busy_cycles, 8);
    chk("product", bus.Product, expv);
    prev_prod = expv;
    if (repulse) begin
      bus.start = 1'b1;
      bus.A = 8'hFF;
      bus.B = 8'hFF;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_pulse_width", bus.done, 1'b0);
    if (repulse) begin
      int extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (bus.done || bus.busy) extra++;
      end
      chk("no_queued_start", extra, 0);
      chk("product_after_ignore", bus.Product, expv);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.A = 8'h00;
    bus.B = 8'h00;
    #12;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_product", bus.Product, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h0D, 8'h0B, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h00, 8'hA5, 1'b0);
    run_op(8'h37, 8'h00, 1'b0);
    run_op(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'h80;
    bus.B = 8'h80;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_product", bus.Product, 16'h0);
    prev_prod = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_no_done", bus.done, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'h03, 8'h05, 1'b0);
    for (int n = 0; n < 25; n++) run_op(8'($urandom), 8'($urandom), 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
